// File: rtl/bnn_pkg.sv
// Shared constants and FSM state type for the BPU accumulate/binarize block.
package bnn_pkg;
   localparam int NUM_BPU   = 8;
   localparam int BPU_OUT_W = 7;
   localparam int ACC_W     = 12;

   typedef enum logic [1:0] {
      ST_ACC = 2'd0,
      ST_BIN = 2'd1,
      ST_OUT = 2'd2
   } acc_state_e;
endpackage

// File: rtl/bpu_acc_bin_if.sv
// Partial-sum input, threshold write port and binarized output handshake.
interface bpu_acc_bin_if #(
   parameter int NUM_BPU = bnn_pkg::NUM_BPU,
   parameter int ACC_W   = bnn_pkg::ACC_W
);
   import bnn_pkg::*;
   localparam int IDX_W = $clog2(NUM_BPU);

   logic [NUM_BPU-1:0][BPU_OUT_W-1:0] bpu_out;
   logic                              in_valid;
   logic                              in_last;
   logic                              in_ready;
   logic                              thr_wr;
   logic [IDX_W-1:0]                  thr_idx;
   logic [ACC_W-1:0]                  thr_data;
   logic                              out_valid;
   logic                              out_ready;
   logic [NUM_BPU-1:0]                out_bits;

   modport master (
      output bpu_out, in_valid, in_last, thr_wr, thr_idx, thr_data, out_ready,
      input  in_ready, out_valid, out_bits
   );

   modport slave (
      input  bpu_out, in_valid, in_last, thr_wr, thr_idx, thr_data, out_ready,
      output in_ready, out_valid, out_bits
   );
endinterface

// File: rtl/bpu_lane_acc.sv
// One lane: saturating signed accumulator, threshold register and >= compare.
module bpu_lane_acc #(
   parameter int ACC_W = bnn_pkg::ACC_W
) (
   input  logic                            clk_bpug,
   input  logic                            rst,
   input  logic                            acc_en_i,
   input  logic                            acc_clr_i,
   input  logic [bnn_pkg::BPU_OUT_W-1:0]   part_i,
   input  logic                            thr_we_i,
   input  logic [ACC_W-1:0]                thr_data_i,
   output logic                            bit_o
);
   import bnn_pkg::*;
   localparam int PW = BPU_OUT_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W-1:0] acc_q, acc_d, thr_q;
   logic        [ACC_W:0]   sum;
   logic                    ovf;

   // One guard bit: overflow shows up as disagreement between the top two bits.
   assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PW){part_i[PW-1]}}, part_i};
   assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

   always_comb begin
      acc_d = acc_q;
      if (acc_clr_i) begin
         acc_d = '0;
      end else if (acc_en_i) begin
         if (ovf) acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
         else     acc_d = sum[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk_bpug) begin
      if (rst) begin
         acc_q <= '0;
         thr_q <= '0;
      end else begin
         acc_q <= acc_d;
         if (thr_we_i) thr_q <= thr_data_i;
      end
   end

   assign bit_o = (acc_q >= thr_q);
endmodule

// File: rtl/bpu_acc_bin.sv
// Accumulate per-lane partial sums, binarize against thresholds, hand out one bit per lane.
// Define BPU_POOL_EN to OR four consecutive pixels (2x2 max pool) into each output.
module bpu_acc_bin #(
   parameter int NUM_BPU = bnn_pkg::NUM_BPU,
   parameter int ACC_W   = bnn_pkg::ACC_W
) (
   input  logic          clk_bpug,
   input  logic          rst,
   bpu_acc_bin_if.slave  bus
);
   import bnn_pkg::*;
   localparam int IDX_W = $clog2(NUM_BPU);

   acc_state_e         state_q, state_d;
   logic [NUM_BPU-1:0] out_bits_q, out_bits_d;
   logic [NUM_BPU-1:0] bin_bits;
   logic               acc_en, acc_clr;

   assign acc_en  = (state_q == ST_ACC) && bus.in_valid;
   assign acc_clr = (state_q == ST_BIN);

   generate
      for (genvar gi = 0; gi < NUM_BPU; gi++) begin : g_lane
         bpu_lane_acc #(.ACC_W(ACC_W)) u_lane (
            .clk_bpug   (clk_bpug),
            .rst        (rst),
            .acc_en_i   (acc_en),
            .acc_clr_i  (acc_clr),
            .part_i     (bus.bpu_out[gi]),
            .thr_we_i   (bus.thr_wr && (bus.thr_idx == IDX_W'(gi))),
            .thr_data_i (bus.thr_data),
            .bit_o      (bin_bits[gi])
         );
      end
   endgenerate

`ifdef BPU_POOL_EN
   logic [1:0]         pix_cnt_q, pix_cnt_d;
   logic [NUM_BPU-1:0] pool_q, pool_d;
`endif

   always_comb begin
      state_d    = state_q;
      out_bits_d = out_bits_q;
`ifdef BPU_POOL_EN
      pix_cnt_d  = pix_cnt_q;
      pool_d     = pool_q;
`endif
      case (state_q)
         ST_ACC: if (bus.in_valid && bus.in_last) state_d = ST_BIN;
         ST_BIN: begin
`ifdef BPU_POOL_EN
            pix_cnt_d = pix_cnt_q + 2'd1;
            pool_d    = pool_q | bin_bits;
            // Fourth pixel of the window: publish the OR and start a fresh window.
            if (pix_cnt_q == 2'd3) begin
               out_bits_d = pool_q | bin_bits;
               pool_d     = '0;
               state_d    = ST_OUT;
            end else begin
               state_d    = ST_ACC;
            end
`else
            out_bits_d = bin_bits;
            state_d    = ST_OUT;
`endif
         end
         ST_OUT: if (bus.out_ready) state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk_bpug) begin
      if (rst) begin
         state_q    <= ST_ACC;
         out_bits_q <= '0;
`ifdef BPU_POOL_EN
         pix_cnt_q  <= '0;
         pool_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         out_bits_q <= out_bits_d;
`ifdef BPU_POOL_EN
         pix_cnt_q  <= pix_cnt_d;
         pool_q     <= pool_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_ACC);
   assign bus.out_valid = (state_q == ST_OUT);
   assign bus.out_bits  = out_bits_q;
endmodule

// File: tb/tb_bpu_acc_bin.sv
// Directed + randomized bench for bpu_acc_bin against a per-pixel arithmetic model.
module tb_bpu_acc_bin;
   localparam int N = 8;
   localparam int W = 12;
`ifdef BPU_POOL_EN
   localparam bit POOL = 1'b1;
`else
   localparam bit POOL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bpu_acc_bin_if #(.NUM_BPU(N), .ACC_W(W)) bus ();
   bpu_acc_bin_if #(.NUM_BPU(N), .ACC_W(8)) bus8 ();

   bpu_acc_bin #(.NUM_BPU(N), .ACC_W(W)) dut  (.clk_bpug(clk), .rst(rst), .bus(bus));
   bpu_acc_bin #(.NUM_BPU(N), .ACC_W(8)) dut8 (.clk_bpug(clk), .rst(rst), .bus(bus8));

   int checks = 0;
   int errors = 0;
   int m_acc[N];
   int m_thr[N];
   logic [N-1:0] m_pool;
   int m_pix;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int x, input int w);
      int lo = -(1 << (w - 1));
      int hi = (1 << (w - 1)) - 1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic [N*7-1:0] all_lanes(input int val);
      logic [N*7-1:0] v;
      for (int i = 0; i < N; i++) v[i*7 +: 7] = 7'(val);
      return v;
   endfunction

   function automatic logic [N*7-1:0] rand_vec();
      logic [63:0] r = {$urandom(), $urandom()};
      return r[N*7-1:0];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_acc[i] = 0;
         m_thr[i] = 0;
      end
      m_pool = '0;
      m_pix  = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.bpu_out  = rand_vec();
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      model_clear();
      $display("reset applied");
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready",  bus.in_ready, 1);
      chk("rst_out_bits",  bus.out_bits, 0);
   endtask

   task automatic wr_thr(input int idx, input int val);
      bus.thr_wr   = 1'b1;
      bus.thr_idx  = 3'(idx);
      bus.thr_data = W'(val);
      @(negedge clk);
      bus.thr_wr = 1'b0;
      m_thr[idx] = val;
      $display("thr write lane %0d = %0d", idx, val);
   endtask

   task automatic beat(input logic [N*7-1:0] v, input bit last);
      chk("in_ready_acc", bus.in_ready, 1);
      bus.bpu_out  = v;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      for (int i = 0; i < N; i++) begin
         logic signed [6:0] p = v[i*7 +: 7];
         m_acc[i] = sat(m_acc[i] + int'(p), W);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Called on the negedge right after the last beat was accepted (block now in BIN).
   task automatic end_pixel(input bit wr_in_bin, input int wr_idx, input int wr_data,
                            input int hold, input bit rst_in_out);
      logic [N-1:0] bits, exp_out;
      chk("bin_out_valid", bus.out_valid, 0);
      chk("bin_in_ready",  bus.in_ready, 0);
      bits = '0;
      for (int i = 0; i < N; i++) begin
         if (m_acc[i] >= m_thr[i]) bits[i] = 1'b1;
         m_acc[i] = 0;
      end
      if (wr_in_bin) begin
         bus.thr_wr   = 1'b1;
         bus.thr_idx  = 3'(wr_idx);
         bus.thr_data = W'(wr_data);
      end
      @(negedge clk);
      bus.thr_wr = 1'b0;
      if (wr_in_bin) m_thr[wr_idx] = wr_data;
      m_pool = m_pool | bits;
      m_pix++;
      if (!POOL || m_pix == 4) begin
         exp_out = POOL ? m_pool : bits;
         m_pool  = '0;
         m_pix   = 0;
         $display("pixel out: bits=%02h expected=%02h", bus.out_bits, exp_out);
         chk("out_valid", bus.out_valid, 1);
         chk("out_bits",  bus.out_bits, exp_out);
         for (int k = 0; k < hold; k++) begin
            bus.bpu_out  = rand_vec();
            bus.in_valid = 1'($urandom_range(1));
            bus.in_last  = 1'($urandom_range(1));
            @(negedge clk);
            chk("hold_valid",    bus.out_valid, 1);
            chk("hold_bits",     bus.out_bits, exp_out);
            chk("hold_in_ready", bus.in_ready, 0);
         end
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
         if (rst_in_out) begin
            do_reset();
         end else begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("accept_valid_drop", bus.out_valid, 0);
            chk("accept_in_ready",   bus.in_ready, 1);
         end
      end else begin
         $display("pixel pooled: bits=%02h", bits);
         chk("pool_no_valid", bus.out_valid, 0);
         chk("pool_in_ready", bus.in_ready, 1);
      end
   endtask

   initial begin
      logic [N*7-1:0] v8;
      rst = 1'b1;
      bus.bpu_out = '0;  bus.in_valid = 0; bus.in_last = 0;
      bus.thr_wr = 0;    bus.thr_idx = '0; bus.thr_data = '0; bus.out_ready = 0;
      bus8.bpu_out = '0; bus8.in_valid = 0; bus8.in_last = 0;
      bus8.thr_wr = 0;   bus8.thr_idx = '0; bus8.thr_data = '0; bus8.out_ready = 0;
      model_clear();
      repeat (2) @(negedge clk);
      do_reset();

      // 8-bit accumulator: +63 / -64 repeated 40 times must clamp, not wrap.
      bus8.thr_wr = 1; bus8.thr_idx = 3'd0; bus8.thr_data = 8'sd127;
      @(negedge clk);
      bus8.thr_idx = 3'd1; bus8.thr_data = -8'sd127;
      @(negedge clk);
      bus8.thr_wr = 0;
      v8 = '0;
      v8[6:0]  = 7'sd63;
      v8[13:7] = -7'sd64;
      for (int p = 0; p < 4; p++) begin
         for (int b = 0; b < 40; b++) begin
            bus8.bpu_out  = v8;
            bus8.in_valid = 1'b1;
            bus8.in_last  = (b == 39);
            @(negedge clk);
         end
         bus8.in_valid = 0; bus8.in_last = 0;
         repeat (2) @(negedge clk);
         if (bus8.out_valid) break;
      end
      $display("acc8 saturation: out_valid=%0b bits=%02h", bus8.out_valid, bus8.out_bits);
      chk("sat8_valid", bus8.out_valid, 1);
      chk("sat8_bits",  bus8.out_bits, 8'hFD);
      bus8.out_ready = 1; @(negedge clk); bus8.out_ready = 0;
      chk("sat8_accept", bus8.out_valid, 0);

      // 5+5+5 against 15, with a threshold write landing during BIN (old value must win).
      wr_thr(0, 15);
      beat(all_lanes(0) | 56'd5, 0);
      beat(all_lanes(0) | 56'd5, 0);
      beat(all_lanes(0) | 56'd5, 1);
      end_pixel(1, 0, 100, 0, 0);

      // 5+5+4 against 15, then a lone +10 shows the accumulator restarted at 0.
      wr_thr(0, 15);
      beat(56'd5, 0); beat(56'd5, 0); beat(56'd4, 1);
      end_pixel(0, 0, 0, 0, 0);
      beat(56'd10, 1);
      end_pixel(0, 0, 0, 0, 0);

      // in_last without in_valid must not close the pixel.
      beat(56'd3, 0);
      bus.in_last = 1'b1;
      @(negedge clk);
      bus.in_last = 1'b0;
      chk("last_only_in_ready", bus.in_ready, 1);
      beat(56'd20, 1);
      end_pixel(0, 0, 0, 0, 0);

      // Lane3 bits 0,0,1,0 over a four-pixel window, output held off 10 cycles.
      do_reset();
      wr_thr(3, 10);
      beat(56'(2) << 21, 1);  end_pixel(0, 0, 0, 10, 0);
      beat(56'(2) << 21, 1);  end_pixel(0, 0, 0, 10, 0);
      beat(56'(20) << 21, 1); end_pixel(0, 0, 0, 10, 0);
      beat(56'(2) << 21, 1);  end_pixel(0, 0, 0, 10, 0);

      // 12-bit saturation both ways.
      for (int i = 0; i < N; i++) wr_thr(i, (i % 2 == 0) ? 2047 : -2047);
      begin
         logic [N*7-1:0] vs;
         for (int i = 0; i < N; i++) vs[i*7 +: 7] = (i % 2 == 0) ? 7'sd63 : -7'sd64;
         for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 40; b++) beat(vs, b == 39);
            end_pixel(0, 0, 0, 0, 0);
         end
      end

      // Randomized pixels with random thresholds and backpressure.
      for (int p = 0; p < 32; p++) begin
         int nb = $urandom_range(6, 1);
         if ($urandom_range(1) == 1) begin
            int r = $urandom_range(200);
            wr_thr($urandom_range(N - 1), r - 100);
         end
         for (int b = 0; b < nb; b++) beat(rand_vec(), b == nb - 1);
         end_pixel(0, 0, 0, $urandom_range(3), 0);
      end

      // Reset mid-accumulation: the next pixel must start from zero.
      beat(all_lanes(40), 0);
      beat(all_lanes(40), 0);
      do_reset();
      for (int i = 0; i < N; i++) wr_thr(i, 20);
      for (int p = 0; p < 4; p++) begin
         beat(all_lanes(10), 1);
         end_pixel(0, 0, 0, 0, 0);
      end

      // Reset while an output is pending.
      for (int p = 0; p < 4; p++) begin
         beat(rand_vec(), 1);
         end_pixel(0, 0, 0, 2, 1);
      end
      beat(all_lanes(1), 1);
      end_pixel(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
